// File: rtl/ads_spi_slave24_if.sv
// Bus bundle for the 24-bit ADS SPI responder: serial pins plus the
// parallel tx/rx handshake. The slave modport is the responder side.
interface ads_spi_slave24_if #(
   parameter int WIDTH = 24
);
   logic             cs_n;
   logic             sclk;
   logic             mosi;
   logic             miso;
   logic [WIDTH-1:0] tx_data;
   logic             tx_valid;
   logic             tx_ready;
   logic [WIDTH-1:0] rx_data;
   logic             rx_valid;
   logic             busy;
   logic             frame_err;
   logic             tx_underrun;

   modport slave (
      input  cs_n, sclk, mosi, tx_data, tx_valid,
      output miso, tx_ready, rx_data, rx_valid, busy, frame_err, tx_underrun
   );

   modport master (
      output cs_n, sclk, mosi, tx_data, tx_valid,
      input  miso, tx_ready, rx_data, rx_valid, busy, frame_err, tx_underrun
   );
endinterface

// File: rtl/ads_spi_slave24.sv
// SPI responder (CPOL=0, CPHA=1, MSB first) for the far end of the ADS link.
// sclk/cs_n/mosi are oversampled in the clk domain. A one-word holding buffer
// feeds the response shift register at frame start.
// Optional: define ADS_SPI_SLAVE_DRDY_EN to add the drdy_n output (ADS1220 DRDY).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no frame open; waiting for the first sclk rise with cs_n low
// ST_SHIFT | frame open; drive miso on rises, capture mosi on falls
// ST_DONE  | WIDTH bits received; edges ignored until cs_n rise / timeout
module ads_spi_slave24 #(
   parameter int WIDTH       = 24,
   parameter int SYNC_STAGES = 2,
   parameter int IDLE_TMO    = 64
) (
   input  logic               clk,
   input  logic               rst_n,
   ads_spi_slave24_if.slave   bus
`ifdef ADS_SPI_SLAVE_DRDY_EN
   ,
   output logic               drdy_n
`endif
);

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int TMO_W = (IDLE_TMO > 1) ? $clog2(IDLE_TMO) : 1;
   localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'((IDLE_TMO > 0) ? IDLE_TMO - 1 : 0);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

   state_t state_q, state_d;

   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic                   sclk_prev_q, sclk_prev_d;

   logic [WIDTH-1:0] hold_q, hold_d;
   logic             hold_full_q, hold_full_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [WIDTH-1:0] rx_shreg_q, rx_shreg_d;
   logic [WIDTH-1:0] rx_data_q, rx_data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             miso_q, miso_d;
   logic             rx_valid_q, rx_valid_d;
   logic             frame_err_q, frame_err_d;
   logic             underrun_q, underrun_d;
   logic             busy_q, busy_d;
`ifdef ADS_SPI_SLAVE_DRDY_EN
   logic             drdy_q, drdy_d;
`endif

   logic sclk_s, cs_s, mosi_s;
   logic sclk_rise, sclk_fall, tmo_hit, frame_end, start, xfer;
   logic [WIDTH-1:0] load_word;

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign cs_s      = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign sclk_fall = ~sclk_s & sclk_prev_q;
   assign tmo_hit   = (IDLE_TMO != 0) && (tmo_q == '0) && !sclk_rise && !sclk_fall;
   // cs_n high while a frame is open is the rise, since frames only open with cs_n low
   assign frame_end = cs_s | tmo_hit;
   assign start     = (state_q == ST_IDLE) & sclk_rise & ~cs_s;
   assign xfer      = bus.tx_valid & ~hold_full_q;
   assign load_word = hold_full_q ? hold_q : '0;

   assign bus.miso        = miso_q;
   assign bus.tx_ready    = ~hold_full_q;
   assign bus.rx_data     = rx_data_q;
   assign bus.rx_valid    = rx_valid_q;
   assign bus.busy        = busy_q;
   assign bus.frame_err   = frame_err_q;
   assign bus.tx_underrun = underrun_q;
`ifdef ADS_SPI_SLAVE_DRDY_EN
   assign drdy_n = drdy_q;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; frame end outranks any coincident sclk edge
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = ST_SHIFT;
         ST_SHIFT: begin
            if (frame_end)                         state_d = ST_IDLE;
            else if (sclk_fall && cnt_q == CNT_LAST) state_d = ST_DONE;
         end
         ST_DONE:  if (frame_end) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Output and datapath next values
   always_comb begin
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
      cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], bus.cs_n};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
      sclk_prev_d = sclk_s;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      shreg_d     = shreg_q;
      rx_shreg_d  = rx_shreg_q;
      rx_data_d   = rx_data_q;
      cnt_d       = cnt_q;
      tmo_d       = tmo_q;
      miso_d      = miso_q;
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;
      underrun_d  = 1'b0;
      busy_d      = (state_d != ST_IDLE);
`ifdef ADS_SPI_SLAVE_DRDY_EN
      drdy_d      = drdy_q;
      if (state_q == ST_SHIFT && sclk_fall && cnt_q == '0 && !frame_end) drdy_d = 1'b1;
      else if (hold_full_q)                                              drdy_d = 1'b0;
`endif

      // Holding buffer: the frame-start load always sees the pre-transfer contents
      if (start && hold_full_q) hold_full_d = 1'b0;
      if (xfer) begin
         hold_d      = bus.tx_data;
         hold_full_d = 1'b1;
      end

      // Idle-timeout down-counter, reloaded on every sclk edge
      if (state_q == ST_IDLE || sclk_rise || sclk_fall) tmo_d = TMO_LOAD;
      else if (tmo_q != '0)                             tmo_d = tmo_q - 1'b1;

      case (state_q)
         ST_IDLE: begin
            miso_d = 1'b0;
            cnt_d  = '0;
            if (start) begin
               miso_d     = load_word[WIDTH-1];
               shreg_d    = load_word << 1;
               rx_shreg_d = '0;
               underrun_d = ~hold_full_q;
            end
         end
         ST_SHIFT: begin
            if (frame_end) begin
               frame_err_d = (cnt_q != '0);
               miso_d      = 1'b0;
               shreg_d     = '0;
            end else begin
               if (sclk_rise) begin
                  miso_d  = shreg_q[WIDTH-1];
                  shreg_d = shreg_q << 1;
               end
               if (sclk_fall) begin
                  rx_shreg_d = {rx_shreg_q[WIDTH-2:0], mosi_s};
                  if (cnt_q != CNT_FULL) cnt_d = cnt_q + 1'b1;
                  if (cnt_q == CNT_LAST) begin
                     rx_data_d  = {rx_shreg_q[WIDTH-2:0], mosi_s};
                     rx_valid_d = 1'b1;
                     miso_d     = 1'b0;
                  end
               end
            end
         end
         ST_DONE: begin
            miso_d = 1'b0;
            if (frame_end) shreg_d = '0;
         end
         default: miso_d = 1'b0;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync_q <= '0;
         cs_sync_q   <= '1;
         mosi_sync_q <= '0;
         sclk_prev_q <= 1'b0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         shreg_q     <= '0;
         rx_shreg_q  <= '0;
         rx_data_q   <= '0;
         cnt_q       <= '0;
         tmo_q       <= TMO_LOAD;
         miso_q      <= 1'b0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         underrun_q  <= 1'b0;
         busy_q      <= 1'b0;
`ifdef ADS_SPI_SLAVE_DRDY_EN
         drdy_q      <= 1'b1;
`endif
      end else begin
         sclk_sync_q <= sclk_sync_d;
         cs_sync_q   <= cs_sync_d;
         mosi_sync_q <= mosi_sync_d;
         sclk_prev_q <= sclk_prev_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         shreg_q     <= shreg_d;
         rx_shreg_q  <= rx_shreg_d;
         rx_data_q   <= rx_data_d;
         cnt_q       <= cnt_d;
         tmo_q       <= tmo_d;
         miso_q      <= miso_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         underrun_q  <= underrun_d;
         busy_q      <= busy_d;
`ifdef ADS_SPI_SLAVE_DRDY_EN
         drdy_q      <= drdy_d;
`endif
      end
   end

endmodule

// File: tb/tb_ads_spi_slave24.sv
// Directed bench for ads_spi_slave24: a bit-banged SPI master at sclk=clk/8,
// pulse counters on the one-clk status outputs, hand-computed expectations.
module tb_ads_spi_slave24;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ads_spi_slave24_if #(.WIDTH(24)) bus ();
`ifdef ADS_SPI_SLAVE_DRDY_EN
   logic drdy_n;
`endif

   ads_spi_slave24 #(
      .WIDTH       (24),
      .SYNC_STAGES (2),
      .IDLE_TMO    (64)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
`ifdef ADS_SPI_SLAVE_DRDY_EN
      ,
      .drdy_n (drdy_n)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;
   int n_rxv   = 0;
   int n_ferr  = 0;
   int n_und   = 0;

   logic [23:0] rd1, rd2;
   int base_rxv, base_ferr, base_und;

   // Count one-clk status pulses
   always @(negedge clk) begin
      if (bus.rx_valid)    n_rxv++;
      if (bus.frame_err)   n_ferr++;
      if (bus.tx_underrun) n_und++;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic snap();
      base_rxv  = n_rxv;
      base_ferr = n_ferr;
      base_und  = n_und;
   endtask

   task automatic push(input logic [23:0] w);
      @(negedge clk);
      bus.tx_data  = w;
      bus.tx_valid = 1'b1;
      @(negedge clk);
      bus.tx_valid = 1'b0;
   endtask

   // Master: drive data on sclk rise, sample miso just before sclk fall
   task automatic spi_frame(input logic [23:0] w, input int nbits, input bit end_cs,
                            output logic [23:0] rd);
      rd = '0;
      @(negedge clk);
      bus.cs_n = 1'b0;
      wait_clk(4);
      for (int i = 0; i < nbits; i++) begin
         bus.mosi = w[23-i];
         bus.sclk = 1'b1;
         wait_clk(4);
         rd = {rd[22:0], bus.miso};
         bus.sclk = 1'b0;
         wait_clk(4);
      end
      wait_clk(4);
      if (end_cs) begin
         bus.cs_n = 1'b1;
         wait_clk(8);
      end
   endtask

   initial begin
      bus.cs_n     = 1'b1;
      bus.sclk     = 1'b0;
      bus.mosi     = 1'b0;
      bus.tx_data  = '0;
      bus.tx_valid = 1'b0;
      wait_clk(3);
      check_eq("rst_miso",     bus.miso, 0);
      check_eq("rst_rx_data",  bus.rx_data, 0);
      check_eq("rst_rx_valid", bus.rx_valid, 0);
      check_eq("rst_busy",     bus.busy, 0);
      check_eq("rst_ferr",     bus.frame_err, 0);
      check_eq("rst_underrun", bus.tx_underrun, 0);
      check_eq("rst_tx_ready", bus.tx_ready, 1);
      rst_n = 1'b1;
      wait_clk(2);

      // 1: preloaded word out, 123456 in
      push(24'hA5C3F0);
      check_eq("t1_ready_low", bus.tx_ready, 0);
      snap();
      spi_frame(24'h123456, 24, 1'b1, rd1);
      check_eq("t1_miso",     rd1, 24'hA5C3F0);
      check_eq("t1_rx_data",  bus.rx_data, 24'h123456);
      check_eq("t1_rxv_cnt",  n_rxv - base_rxv, 1);
      check_eq("t1_busy_end", bus.busy, 0);
      check_eq("t1_ready",    bus.tx_ready, 1);

      // 2: back-to-back, new word pushed while frame 1 runs
      push(24'h111111);
      fork
         spi_frame(24'hABCDEF, 24, 1'b1, rd1);
         begin
            wait_clk(20);
            check_eq("t2_busy_mid",     bus.busy, 1);
            check_eq("t2_ready_empty",  bus.tx_ready, 1);
            push(24'h654321);
            check_eq("t2_ready_full",   bus.tx_ready, 0);
         end
      join
      spi_frame(24'h0F0F0F, 24, 1'b1, rd2);
      check_eq("t2_miso_f1", rd1, 24'h111111);
      check_eq("t2_miso_f2", rd2, 24'h654321);
      check_eq("t2_rx_data", bus.rx_data, 24'h0F0F0F);
      check_eq("t2_ready",   bus.tx_ready, 1);

      // 3: no preload -> zeros out, one underrun
      snap();
      spi_frame(24'hFFFFFF, 24, 1'b1, rd1);
      check_eq("t3_miso",     rd1, 24'h000000);
      check_eq("t3_underrun", n_und - base_und, 1);
      check_eq("t3_rx_data",  bus.rx_data, 24'hFFFFFF);
      check_eq("t3_ferr",     n_ferr - base_ferr, 0);

      // 4: cs_n rises after 10 bits, then a clean frame
      snap();
      spi_frame(24'h5A5A5A, 10, 1'b1, rd1);
      check_eq("t4_ferr",    n_ferr - base_ferr, 1);
      check_eq("t4_rxv",     n_rxv - base_rxv, 0);
      check_eq("t4_rx_data", bus.rx_data, 24'hFFFFFF);
      check_eq("t4_busy",    bus.busy, 0);
      snap();
      spi_frame(24'h000001, 24, 1'b1, rd1);
      check_eq("t4_rx_next", bus.rx_data, 24'h000001);
      check_eq("t4_ferr2",   n_ferr - base_ferr, 0);

      // 5: cs_n tied low, sclk stalls after 5 bits -> timeout abort
      snap();
      spi_frame(24'hC00000, 5, 1'b0, rd1);
      check_eq("t5_busy_open", bus.busy, 1);
      wait_clk(64 + 4);
      check_eq("t5_ferr",     n_ferr - base_ferr, 1);
      check_eq("t5_busy_tmo", bus.busy, 0);
      check_eq("t5_rx_keep",  bus.rx_data, 24'h000001);

      // 5b: reset mid-frame
      push(24'h777777);
      snap();
      spi_frame(24'h333333, 8, 1'b0, rd1);
      check_eq("t5_busy_pre", bus.busy, 1);
      rst_n = 1'b0;
      #1;
      check_eq("t5r_busy",     bus.busy, 0);
      check_eq("t5r_miso",     bus.miso, 0);
      check_eq("t5r_rx_data",  bus.rx_data, 0);
      check_eq("t5r_tx_ready", bus.tx_ready, 1);
      bus.cs_n = 1'b1;
      bus.sclk = 1'b0;
      wait_clk(2);
      rst_n = 1'b1;
      wait_clk(6);
      check_eq("t5r_ferr", n_ferr - base_ferr, 0);
      check_eq("t5r_rxv",  n_rxv - base_rxv, 0);

`ifdef ADS_SPI_SLAVE_DRDY_EN
      // 6: drdy_n follows the holding buffer
      check_eq("t6_drdy_idle", drdy_n, 1);
      push(24'hABCDEF);
      check_eq("t6_drdy_fill", drdy_n, 1);
      wait_clk(1);
      check_eq("t6_drdy_low", drdy_n, 0);
      spi_frame(24'h000000, 24, 1'b1, rd1);
      check_eq("t6_miso",      rd1, 24'hABCDEF);
      check_eq("t6_drdy_high", drdy_n, 1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
